raptor64_dcache_fill: RTL and testbench
=======================================

RAPTOR64_DCACHE_FILL -- requirements
Module: Raptor64_dcache_fill

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum cycles a single beat waits for ack_i/err_i before aborting.
REQ-002 SHALL have clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have rst_i  input  1  reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have req_i  input  1  fill request, sampled only in IDLE.
REQ-005 SHALL have req_adr_i  input  64  miss byte address; bits [63:5] select the 32-byte line.
REQ-006 SHALL have busy_o, done_o, err_o  output  1 each  fill in progress / success pulse / abort pulse.
REQ-007 SHALL have cyc_o, stb_o, we_o  output  1 each  Wishbone master strobes; we_o is constant 0.
REQ-008 SHALL have cti_o  output  3, bte_o  output  2, sel_o  output  8, adr_o  output  64  burst read controls.
REQ-009 SHALL have ack_i, err_i  input  1 each, and dat_i  input  64  bus read data.
REQ-010 SHALL have ram_wr_o  output  1, ram_sel_o  output  8, ram_wadr_o  output  12 [14:3], ram_dat_o  output  64  data-cache RAM write port.
REQ-011 SHALL have tag_wr_o  output  1, tag_adr_o  output  10 [14:5], tag_o  output  49 [63:15], tag_v_o  output  1  tag RAM write port.

Function
REQ-012 SHALL implement states IDLE, FETCH, DONE; line = 4 beats of 64 bits; beat counter 2 bits.
REQ-013 In IDLE with req_i=1 at an edge, SHALL latch req_adr_i[63:5], clear the beat counter and timeout counter, and enter FETCH.
REQ-014 For the first FETCH cycle, SHALL drive tag_wr_o=1, tag_v_o=0, tag_adr_o=line[14:5], invalidating the victim line before any data write.
REQ-015 In FETCH, SHALL drive cyc_o=stb_o=1, sel_o=8'hFF, bte_o=2'b00, adr_o={line,beat,3'b000}; cti_o=3'b010 for beats 0-2, 3'b111 for beat 3.
REQ-016 On each ack_i in FETCH, SHALL register dat_i and the beat address, and drive ram_wr_o=1, ram_sel_o=8'hFF, ram_wadr_o={line[14:5],beat}, ram_dat_o=data for exactly the following cycle (latency 1).
REQ-017 On each ack_i, SHALL increment the beat counter and clear the timeout counter; ack on beat 3 SHALL drop cyc_o/stb_o at that edge and enter DONE.
REQ-018 In DONE (one cycle), SHALL pulse done_o=1 and tag_wr_o=1, tag_v_o=1, tag_o=line[63:15], tag_adr_o=line[14:5], concurrent with the beat-3 RAM write, then return to IDLE.
REQ-019 err_i=1 in FETCH SHALL abort: drop cyc_o/stb_o at that edge, pulse err_o for one cycle, return to IDLE, write no valid tag; err_i SHALL take priority over a simultaneous ack_i (that beat not written).
REQ-020 TIMEOUT consecutive FETCH cycles without ack_i or err_i SHALL abort exactly as REQ-019.
REQ-021 busy_o SHALL be 1 in FETCH and DONE, 0 in IDLE; req_i outside IDLE SHALL be ignored; a new request SHALL be accepted on the first IDLE cycle.
REQ-022 ack_i/err_i outside FETCH SHALL be ignored.
REQ-023 Wait states: cyc_o, stb_o, adr_o, cti_o SHALL remain stable while ack_i=0.

Reset
REQ-024 rst_i=1 at an edge SHALL force IDLE and clear all outputs to 0 (cyc_o, stb_o, we_o, cti_o, bte_o, sel_o, adr_o, busy_o, done_o, err_o, ram_*, tag_*), including mid-burst, with no further RAM or tag write.
REQ-025 After rst_i deasserts, the block SHALL accept req_i in the first cycle.

Verification
REQ-026 Zero-wait slave, req_adr_i=64'h0000_0000_1234_5678 at edge E0 -> tag invalidate (adr 10'h2B3) after E0; adr_o 5678&~1F +0,8,10,18; ram_wadr_o 12'hACC..ACF after E1..E4; done_o and tag_v_o=1 with tag_o=0x2468 after E4; busy_o 0 after E5.
REQ-027 Slave inserting 2 wait states per beat -> adr_o/cti_o held stable, 4 RAM writes, done_o once, cti_o=111 only on beat 3.
REQ-028 err_i on beat 2 with ack_i also high -> only beats 0-1 written, err_o pulse, no valid tag write, cyc_o low next cycle.
REQ-029 No ack_i for TIMEOUT=255 cycles on beat 0 -> err_o after cycle 255, IDLE, no RAM write.
REQ-030 rst_i asserted after beat 1 ack -> all outputs 0 next cycle, no done_o/tag write; new req_i after reset completes normally.
REQ-031 req_i held high continuously -> back-to-back fills separated by exactly one IDLE cycle; req_i during FETCH ignored.

Source files
------------

// File: rtl/raptor64_dcache_fill.sv
// Data-cache line fill engine: fetches a 32-byte line as a 4-beat Wishbone
// incrementing burst, writes it into the data RAM and validates the tag.
module raptor64_dcache_fill #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [63:0] req_adr_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [2:0]  cti_o,
  output logic [1:0]  bte_o,
  output logic [7:0]  sel_o,
  output logic [63:0] adr_o,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic [63:0] dat_i,
  output logic        ram_wr_o,
  output logic [7:0]  ram_sel_o,
  output logic [11:0] ram_wadr_o,
  output logic [63:0] ram_dat_o,
  output logic        tag_wr_o,
  output logic [9:0]  tag_adr_o,
  output logic [48:0] tag_o,
  output logic        tag_v_o
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [58:0]   line_q, line_d;
  logic [1:0]    beat_q, beat_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          first_q, first_d;
  logic          err_q, err_d;
  logic          ram_wr_q, ram_wr_d;
  logic [11:0]   ram_wadr_q, ram_wadr_d;
  logic [63:0]   ram_dat_q, ram_dat_d;

  logic unused_adr;
  assign unused_adr = ^req_adr_i[4:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      line_q     <= '0;
      beat_q     <= '0;
      tmo_q      <= '0;
      first_q    <= 1'b0;
      err_q      <= 1'b0;
      ram_wr_q   <= 1'b0;
      ram_wadr_q <= '0;
      ram_dat_q  <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      beat_q     <= beat_d;
      tmo_q      <= tmo_d;
      first_q    <= first_d;
      err_q      <= err_d;
      ram_wr_q   <= ram_wr_d;
      ram_wadr_q <= ram_wadr_d;
      ram_dat_q  <= ram_dat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    beat_d     = beat_q;
    tmo_d      = tmo_q;
    first_d    = first_q;
    err_d      = 1'b0;
    ram_wr_d   = 1'b0;
    ram_wadr_d = ram_wadr_q;
    ram_dat_d  = ram_dat_q;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    cyc_o      = 1'b0;
    stb_o      = 1'b0;
    cti_o      = 3'b000;
    bte_o      = 2'b00;
    sel_o      = 8'h00;
    adr_o      = '0;
    tag_wr_o   = 1'b0;
    tag_adr_o  = '0;
    tag_o      = '0;
    tag_v_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          line_d  = req_adr_i[63:5];
          beat_d  = 2'd0;
          tmo_d   = TMO_LOAD;
          first_d = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        busy_o    = 1'b1;
        cyc_o     = 1'b1;
        stb_o     = 1'b1;
        sel_o     = 8'hFF;
        adr_o     = {line_q, beat_q, 3'b000};
        cti_o     = (beat_q == 2'd3) ? 3'b111 : 3'b010;
        // victim line is invalidated before any of its data is overwritten
        tag_wr_o  = first_q;
        tag_adr_o = line_q[9:0];
        first_d   = 1'b0;
        if (err_i) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (ack_i) begin
          ram_wr_d   = 1'b1;
          ram_wadr_d = {line_q[9:0], beat_q};
          ram_dat_d  = dat_i;
          beat_d     = beat_q + 2'd1;
          tmo_d      = TMO_LOAD;
          if (beat_q == 2'd3) state_d = S_DONE;
        end else if (tmo_q == '0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end

      S_DONE: begin
        busy_o    = 1'b1;
        done_o    = 1'b1;
        tag_wr_o  = 1'b1;
        tag_v_o   = 1'b1;
        tag_adr_o = line_q[9:0];
        tag_o     = line_q[58:10];
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign err_o      = err_q;
  assign we_o       = 1'b0;
  assign ram_wr_o   = ram_wr_q;
  assign ram_sel_o  = {8{ram_wr_q}};
  assign ram_wadr_o = ram_wadr_q;
  assign ram_dat_o  = ram_dat_q;

endmodule

// File: tb/tb_raptor64_dcache_fill.sv
// Randomized bench for raptor64_dcache_fill: a bench-side Wishbone slave plus
// a transaction-level expectation of RAM writes, tag writes and pulses.
module tb_raptor64_dcache_fill;

  localparam int TMO = 255;

  logic        clk_i = 1'b0;
  logic        rst_i, req_i, ack_i, err_i;
  logic [63:0] req_adr_i, dat_i;
  logic        busy_o, done_o, err_o, cyc_o, stb_o, we_o;
  logic [2:0]  cti_o;
  logic [1:0]  bte_o;
  logic [7:0]  sel_o, ram_sel_o;
  logic [63:0] adr_o, ram_dat_o;
  logic        ram_wr_o, tag_wr_o, tag_v_o;
  logic [11:0] ram_wadr_o;
  logic [9:0]  tag_adr_o;
  logic [48:0] tag_o;

  raptor64_dcache_fill #(.TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .req_adr_i(req_adr_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .cti_o(cti_o), .bte_o(bte_o),
    .sel_o(sel_o), .adr_o(adr_o), .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i),
    .ram_wr_o(ram_wr_o), .ram_sel_o(ram_sel_o), .ram_wadr_o(ram_wadr_o),
    .ram_dat_o(ram_dat_o), .tag_wr_o(tag_wr_o), .tag_adr_o(tag_adr_o),
    .tag_o(tag_o), .tag_v_o(tag_v_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {logic [11:0] wadr; logic [63:0] dat; logic [7:0] sel;} wr_t;
  typedef struct {logic [9:0] adr; logic [48:0] tag; logic conc;} tag_t;

  wr_t  mon_wr[$], exp_wr[$];
  tag_t mon_tag[$];
  int   inv_cnt, done_cnt, err_cnt;
  int   checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // passive observer of the RAM/tag write ports and status pulses
  always @(negedge clk_i) begin
    wr_t  w;
    tag_t t;
    if (ram_wr_o === 1'b1) begin
      w.wadr = ram_wadr_o; w.dat = ram_dat_o; w.sel = ram_sel_o;
      mon_wr.push_back(w);
    end
    if (tag_wr_o === 1'b1) begin
      if (tag_v_o === 1'b1) begin
        t.adr = tag_adr_o; t.tag = tag_o;
        t.conc = (ram_wr_o === 1'b1) && (ram_wadr_o[1:0] == 2'd3);
        mon_tag.push_back(t);
      end else inv_cnt++;
    end
    if (done_o === 1'b1) done_cnt++;
    if (err_o === 1'b1) err_cnt++;
  end

  task automatic clear_mon();
    mon_wr.delete(); exp_wr.delete(); mon_tag.delete();
    inv_cnt = 0; done_cnt = 0; err_cnt = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {cyc_o, stb_o, we_o, cti_o, bte_o, sel_o, busy_o, done_o,
                        err_o, ram_wr_o, ram_sel_o, tag_wr_o, tag_v_o}, '0);
    chk({tag, "_adr"}, adr_o, '0);
    chk({tag, "_rdat"}, ram_dat_o, '0);
    chk({tag, "_tag"}, tag_o, '0);
    chk({tag, "_adrs"}, {tag_adr_o, ram_wadr_o}, '0);
  endtask

  // mode: 0 normal, 1 bus error on beat sel, 2 timeout on beat sel, 3 reset after beat sel ack
  // wfix: wait states per beat, or -1 for random 0..2
  task automatic fill(input logic [63:0] a, input int mode, input int sel, input int wfix);
    logic [63:0] base, d;
    int   waits, n;
    bit   aborted;
    wr_t  w;
    clear_mon();
    base = {a[63:5], 5'b0};
    req_i = 1'b1; req_adr_i = a; ack_i = 1'b0; err_i = 1'b0;
    tick();
    chk("tag_inval", {tag_wr_o, tag_v_o, tag_adr_o}, {1'b1, 1'b0, a[14:5]});
    aborted = 1'b0;
    for (int k = 0; k < 4 && !aborted; k++) begin
      waits = (wfix >= 0) ? wfix : int'($urandom_range(0, 2));
      n = 0;
      while (1) begin
        req_i = 1'($urandom); req_adr_i = {$urandom, $urandom};
        if (mode == 2 && k == sel && !cyc_o) begin
          chk("tmo_len", 64'(n), 64'(TMO));
          aborted = 1'b1;
          break;
        end
        if (n > TMO + 4) begin
          chk("wait_bound", 64'(n), 64'(TMO));
          aborted = 1'b1;
          break;
        end
        chk("bus_ctl", {cyc_o, stb_o, we_o, sel_o, bte_o, cti_o},
            {1'b1, 1'b1, 1'b0, 8'hFF, 2'b00, (k == 3) ? 3'b111 : 3'b010});
        chk("bus_adr", adr_o, base + 64'(8 * k));
        if (n == waits && !(mode == 2 && k == sel)) begin
          d = {$urandom, $urandom};
          dat_i = d;
          if (mode == 1 && k == sel) begin
            err_i = 1'b1; ack_i = 1'($urandom);
            tick();
            aborted = 1'b1;
          end else begin
            ack_i = 1'b1;
            w.wadr = {a[14:5], 2'(k)}; w.dat = d; w.sel = 8'hFF;
            exp_wr.push_back(w);
            tick();
          end
          break;
        end
        ack_i = 1'b0; err_i = 1'b0; dat_i = {$urandom, $urandom};
        n++;
        tick();
      end
      ack_i = 1'b0; err_i = 1'b0;
      if (mode == 3 && k == sel && !aborted) begin
        rst_i = 1'b1; ack_i = 1'($urandom);
        tick();
        chk_all_zero("midrst");
        rst_i = 1'b0; ack_i = 1'b0;
        aborted = 1'b1;
      end
    end
    req_i = 1'b0; ack_i = 1'b0; err_i = 1'b0;
    if (mode == 0) begin
      chk("done_cyc", {cyc_o, busy_o, done_o}, 3'b011);
      tick();
      chk("idle_busy", {busy_o, cyc_o}, 2'b00);
    end else if (mode == 1 || mode == 2) begin
      chk("abort_cyc", {cyc_o, busy_o, err_o}, 3'b001);
      tick();
    end
    tick();
    chk("n_wr", 64'(mon_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < mon_wr.size() && i < exp_wr.size(); i++) begin
      chk("wr_adr", mon_wr[i].wadr, exp_wr[i].wadr);
      chk("wr_dat", mon_wr[i].dat, exp_wr[i].dat);
      chk("wr_sel", mon_wr[i].sel, exp_wr[i].sel);
    end
    chk("n_vtag", 64'(mon_tag.size()), (mode == 0) ? 64'd1 : 64'd0);
    if (mode == 0 && mon_tag.size() == 1) begin
      chk("vtag_adr", mon_tag[0].adr, a[14:5]);
      chk("vtag_val", mon_tag[0].tag, a[63:15]);
      chk("vtag_conc", mon_tag[0].conc, 1'b1);
    end
    chk("n_inv", 64'(inv_cnt), 64'd1);
    chk("n_done", 64'(done_cnt), (mode == 0) ? 64'd1 : 64'd0);
    chk("n_err", 64'(err_cnt), (mode == 1 || mode == 2) ? 64'd1 : 64'd0);
  endtask

  task automatic idle_noise(input int cycles);
    clear_mon();
    req_i = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      ack_i = 1'($urandom); err_i = 1'($urandom); dat_i = {$urandom, $urandom};
      tick();
      chk("idle_busy_n", {busy_o, cyc_o}, 2'b00);
    end
    ack_i = 1'b0; err_i = 1'b0;
    tick();
    chk("idle_events", {32'(mon_wr.size()), 16'(err_cnt), 16'(done_cnt)}, '0);
  endtask

  initial begin
    int mode;
    rst_i = 1'b1; req_i = 1'b0; req_adr_i = '0; ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
    clear_mon();
    repeat (3) tick();
    chk_all_zero("reset");
    rst_i = 1'b0;

    // zero-wait reference fill
    fill(64'h0000_0000_1234_5678, 0, 0, 0);
    if (mon_wr.size() == 4) begin
      chk("ref_wadr0", mon_wr[0].wadr, 12'hACC);
      chk("ref_wadr3", mon_wr[3].wadr, 12'hACF);
    end else chk("ref_nwr", 64'(mon_wr.size()), 64'd4);
    if (mon_tag.size() == 1) begin
      chk("ref_tag", mon_tag[0].tag, 49'h2468);
      chk("ref_tadr", mon_tag[0].adr, 10'h2B3);
    end else chk("ref_ntag", 64'(mon_tag.size()), 64'd1);

    fill({$urandom, $urandom}, 0, 0, 2);
    fill({$urandom, $urandom}, 1, 2, 0);
    fill({$urandom, $urandom}, 2, 0, 0);
    fill({$urandom, $urandom}, 3, 1, 0);
    fill({$urandom, $urandom}, 0, 0, -1);
    idle_noise(6);

    for (int r = 0; r < 30; r++) begin
      mode = int'($urandom_range(0, 9));
      case (mode)
        6, 7:    fill({$urandom, $urandom}, 1, int'($urandom_range(0, 3)), -1);
        8:       fill({$urandom, $urandom}, 3, int'($urandom_range(0, 2)), -1);
        default: fill({$urandom, $urandom}, 0, 0, -1);
      endcase
      if ($urandom_range(0, 3) == 0) idle_noise(3);
    end
    fill({$urandom, $urandom}, 2, 2, -1);

    // request held high: fills separated by exactly one idle cycle
    clear_mon();
    req_i = 1'b1; req_adr_i = {$urandom, $urandom};
    for (int i = 0; i < 18; i++) begin
      tick();
      chk("b2b_busy", busy_o, ((i % 6) != 5));
      ack_i = cyc_o; dat_i = {$urandom, $urandom};
      if (i == 17) req_i = 1'b0;
    end
    for (int i = 0; i < 10 && busy_o; i++) begin
      tick();
      ack_i = cyc_o;
    end
    ack_i = 1'b0;
    tick();
    chk("b2b_done", 64'(done_cnt), 64'd3);
    chk("b2b_nwr", 64'(mon_wr.size()), 64'd12);
    chk("b2b_idle", busy_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
